// File: rtl/debug_ckpt_pkg.sv
// Shared types and constants for the debug-port checkpoint/rollback sequencer.
package debug_ckpt_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_HALT,
        ST_REQ,
        ST_WAIT,
        ST_RESUME,
        ST_DONE
    } state_e;

    typedef enum logic [1:0] {
        OP_SAVE,
        OP_RESTORE,
        OP_VERIFY
    } op_e;

    localparam logic [14:0] DEFAULT_GPR_BASE = 15'h400;
    localparam int unsigned ADDR_STEP        = 4;

    function automatic logic [14:0] gpr_addr(input logic [14:0] base, input logic [14:0] idx);
        return base + idx * 15'(ADDR_STEP);
    endfunction

endpackage

// File: rtl/ckpt_shadow_rf.sv
// Shadow GPR file: one synchronous write port, one asynchronous read port, no reset.
module ckpt_shadow_rf #(
    parameter  int NUM_REGS = 32,
    localparam int IDX_W    = $clog2(NUM_REGS)
) (
    input  logic             clk_i,
    input  logic             we,
    input  logic [IDX_W-1:0] waddr,
    input  logic [31:0]      wdata,
    input  logic [IDX_W-1:0] raddr,
    output logic [31:0]      rdata
);

    logic [31:0] mem [NUM_REGS];

    always_ff @(posedge clk_i) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/debug_ckpt_ctrl.sv
// Checkpoint save / rollback sequencer driving the core debug slave port.
// Optional read-back verify of restores when DEBUG_CKPT_VERIFY_EN is defined.
module debug_ckpt_ctrl
    import debug_ckpt_pkg::*;
#(
    parameter int          NUM_REGS = 32,
    parameter logic [14:0] GPR_BASE = DEFAULT_GPR_BASE
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        save_req_i,
    input  logic        restore_req_i,
    output logic        busy_o,
    output logic        done_o,
    output logic        err_o,
    output logic        ckpt_valid_o,
    output logic        mismatch_o,
    output logic        debug_req_o,
    output logic [14:0] debug_addr_o,
    output logic        debug_we_o,
    output logic [31:0] debug_wdata_o,
    input  logic        debug_gnt_i,
    input  logic        debug_rvalid_i,
    input  logic [31:0] debug_rdata_i,
    output logic        debug_halt_o,
    output logic        debug_resume_o,
    input  logic        debug_halted_i
);

    localparam int               IDX_W    = $clog2(NUM_REGS);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_REGS - 1);

    state_e           state;
    op_e              op;
    logic [IDX_W-1:0] idx;
    logic             busy_q, done_q, err_q, ckpt_valid_q;
    logic             req_q, we_q, halt_q, resume_q;
    logic [14:0]      addr_q;
    logic             rf_we;
    logic [31:0]      rf_rdata;

    assign rf_we = (state == ST_WAIT) && debug_rvalid_i && (op == OP_SAVE);

    ckpt_shadow_rf #(.NUM_REGS(NUM_REGS)) u_shadow (
        .clk_i (clk_i),
        .we    (rf_we),
        .waddr (idx),
        .wdata (debug_rdata_i),
        .raddr (idx),
        .rdata (rf_rdata)
    );

`ifdef DEBUG_CKPT_VERIFY_EN
    logic mismatch_q;
    assign mismatch_o = mismatch_q;
`else
    assign mismatch_o = 1'b0;
`endif

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state        <= ST_IDLE;
            op           <= OP_SAVE;
            idx          <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            err_q        <= 1'b0;
            ckpt_valid_q <= 1'b0;
            req_q        <= 1'b0;
            we_q         <= 1'b0;
            halt_q       <= 1'b0;
            resume_q     <= 1'b0;
            addr_q       <= '0;
`ifdef DEBUG_CKPT_VERIFY_EN
            mismatch_q   <= 1'b0;
`endif
        end else begin
            done_q <= 1'b0;
            err_q  <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (restore_req_i) begin
                        if (ckpt_valid_q) begin
                            state  <= ST_HALT;
                            op     <= OP_RESTORE;
                            busy_q <= 1'b1;
                            halt_q <= 1'b1;
`ifdef DEBUG_CKPT_VERIFY_EN
                            mismatch_q <= 1'b0;
`endif
                        end else begin
                            err_q <= 1'b1;
                        end
                    end else if (save_req_i) begin
                        // Invalidate up front so an aborted save cannot leave a stale checkpoint.
                        state        <= ST_HALT;
                        op           <= OP_SAVE;
                        busy_q       <= 1'b1;
                        halt_q       <= 1'b1;
                        ckpt_valid_q <= 1'b0;
                    end
                end
                ST_HALT: begin
                    if (debug_halted_i) begin
                        state  <= ST_REQ;
                        idx    <= '0;
                        halt_q <= 1'b0;
                        req_q  <= 1'b1;
                        addr_q <= gpr_addr(GPR_BASE, 15'd0);
                        we_q   <= (op == OP_RESTORE);
                    end
                end
                ST_REQ: begin
                    if (debug_gnt_i) begin
                        state <= ST_WAIT;
                        req_q <= 1'b0;
                        we_q  <= 1'b0;
                    end
                end
                ST_WAIT: begin
                    if (debug_rvalid_i) begin
`ifdef DEBUG_CKPT_VERIFY_EN
                        if (op == OP_VERIFY && debug_rdata_i != rf_rdata) begin
                            mismatch_q <= 1'b1;
                        end
`endif
                        if (idx == LAST_IDX) begin
`ifdef DEBUG_CKPT_VERIFY_EN
                            if (op == OP_RESTORE) begin
                                state  <= ST_REQ;
                                op     <= OP_VERIFY;
                                idx    <= '0;
                                req_q  <= 1'b1;
                                addr_q <= gpr_addr(GPR_BASE, 15'd0);
                                we_q   <= 1'b0;
                            end else begin
                                state    <= ST_RESUME;
                                resume_q <= 1'b1;
                            end
`else
                            state    <= ST_RESUME;
                            resume_q <= 1'b1;
`endif
                        end else begin
                            state  <= ST_REQ;
                            idx    <= idx + IDX_W'(1);
                            req_q  <= 1'b1;
                            addr_q <= gpr_addr(GPR_BASE, 15'(idx) + 15'd1);
                            we_q   <= (op == OP_RESTORE);
                        end
                    end
                end
                ST_RESUME: begin
                    if (!debug_halted_i) begin
                        state    <= ST_DONE;
                        resume_q <= 1'b0;
                        done_q   <= 1'b1;
                        if (op == OP_SAVE) begin
                            ckpt_valid_q <= 1'b1;
                        end
                    end
                end
                ST_DONE: begin
                    state  <= ST_IDLE;
                    busy_q <= 1'b0;
                end
                default: begin
                    state  <= ST_IDLE;
                    busy_q <= 1'b0;
                end
            endcase
        end
    end

    assign busy_o         = busy_q;
    assign done_o         = done_q;
    assign err_o          = err_q;
    assign ckpt_valid_o   = ckpt_valid_q;
    assign debug_req_o    = req_q;
    assign debug_addr_o   = addr_q;
    assign debug_we_o     = we_q;
    assign debug_wdata_o  = we_q ? rf_rdata : 32'd0;
    assign debug_halt_o   = halt_q;
    assign debug_resume_o = resume_q;

endmodule

// File: tb/tb_debug_ckpt_ctrl.sv
// Scoreboard bench for debug_ckpt_ctrl with a behavioural debug-slave/core model.
module tb_debug_ckpt_ctrl;

    localparam int N = 32;
`ifdef DEBUG_CKPT_VERIFY_EN
    localparam int RESTORE_CYCLES = 1 + 4 * N + 1 + 1;
`else
    localparam int RESTORE_CYCLES = 1 + 2 * N + 1 + 1;
`endif
    localparam int SAVE_CYCLES = 1 + 2 * N + 1 + 1;
    localparam int BP_CYCLES   = 1 + N * (4 + 3) + 1 + 1;

    logic        clk = 1'b0;
    logic        rst_ni, save_req_i, restore_req_i;
    logic        busy_o, done_o, err_o, ckpt_valid_o, mismatch_o;
    logic        debug_req_o, debug_we_o, debug_halt_o, debug_resume_o;
    logic [14:0] debug_addr_o;
    logic [31:0] debug_wdata_o, debug_rdata_i;
    logic        debug_gnt_i, debug_rvalid_i, debug_halted_i;

    debug_ckpt_ctrl dut (
        .clk_i          (clk),
        .rst_ni         (rst_ni),
        .save_req_i     (save_req_i),
        .restore_req_i  (restore_req_i),
        .busy_o         (busy_o),
        .done_o         (done_o),
        .err_o          (err_o),
        .ckpt_valid_o   (ckpt_valid_o),
        .mismatch_o     (mismatch_o),
        .debug_req_o    (debug_req_o),
        .debug_addr_o   (debug_addr_o),
        .debug_we_o     (debug_we_o),
        .debug_wdata_o  (debug_wdata_o),
        .debug_gnt_i    (debug_gnt_i),
        .debug_rvalid_i (debug_rvalid_i),
        .debug_rdata_i  (debug_rdata_i),
        .debug_halt_o   (debug_halt_o),
        .debug_resume_o (debug_resume_o),
        .debug_halted_i (debug_halted_i)
    );

    always #5 clk = ~clk;

    int nChecks = 0;
    int nPassed = 0;

    task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
        nChecks++;
        if (actual === expected) nPassed++;
        else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
    endtask

    // Access records are {we, addr, wdata}; read records carry wdata 0.
    logic [47:0] expQ[$];
    logic [47:0] obsQ[$];

    logic [31:0] gpr [N];
    int  gntDelay = 0, rvDelay = 0;
    bit  dropX5 = 1'b0;
    int  busyCnt = 0, doneCnt = 0, errCnt = 0, haltRise = 0, resumeRise = 0, stallErr = 0;

    // Debug slave / core model plus output monitor, all sampled on the falling edge.
    initial begin
        bit          rvPending, reqPrev, haltPrev, resumePrev;
        int          gWait, rWait;
        logic [31:0] rdVal;
        logic [47:0] held;
        rvPending = 0; reqPrev = 0; haltPrev = 0; resumePrev = 0;
        gWait = 0; rWait = 0; rdVal = '0; held = '0;
        debug_gnt_i = 0; debug_rvalid_i = 0; debug_rdata_i = '0; debug_halted_i = 0;
        forever begin
            @(negedge clk);
            if (busy_o) busyCnt++;
            if (done_o) doneCnt++;
            if (err_o) errCnt++;
            if (debug_halt_o && !haltPrev) haltRise++;
            if (debug_resume_o && !resumePrev) resumeRise++;
            haltPrev = debug_halt_o;
            resumePrev = debug_resume_o;
            if (debug_halt_o) debug_halted_i = 1;
            else if (debug_resume_o) debug_halted_i = 0;

            debug_gnt_i = 0;
            debug_rvalid_i = 0;
            if (rvPending) begin
                if (rWait == 0) begin
                    debug_rvalid_i = 1;
                    debug_rdata_i = rdVal;
                    rvPending = 0;
                end else rWait--;
            end else if (debug_req_o) begin
                logic [47:0] cur;
                cur = {debug_we_o, debug_addr_o, debug_we_o ? debug_wdata_o : 32'd0};
                if (!reqPrev) begin
                    held = cur;
                    gWait = gntDelay;
                end else if (cur !== held) stallErr++;
                if (gWait == 0) begin
                    int i;
                    debug_gnt_i = 1;
                    obsQ.push_back(cur);
                    i = (int'(debug_addr_o) - 'h400) / 4;
                    rdVal = '0;
                    if (i >= 0 && i < N) begin
                        if (debug_we_o && !(dropX5 && i == 5)) gpr[i] = debug_wdata_o;
                        rdVal = gpr[i];
                    end
                    rvPending = 1;
                    rWait = rvDelay;
                end else gWait--;
            end
            reqPrev = debug_req_o;
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(negedge clk);
            #1;
        end
    endtask

    task automatic applyStimulus(input bit save, input bit restore);
        save_req_i = save;
        restore_req_i = restore;
        tick(1);
        save_req_i = 0;
        restore_req_i = 0;
    endtask

    task automatic pushSeq(input bit isWrite, input logic [31:0] base);
        for (int i = 0; i < N; i++)
            expQ.push_back({isWrite, 15'(15'h400 + 4 * i), isWrite ? base + 32'(i) : 32'd0});
    endtask

    task automatic pushRestore(input logic [31:0] base);
        pushSeq(1, base);
`ifdef DEBUG_CKPT_VERIFY_EN
        pushSeq(0, 32'd0);
`endif
    endtask

    task automatic waitDone(input string tag);
        int start;
        bit seen;
        start = doneCnt;
        seen = 0;
        for (int c = 0; c < 3000 && !seen; c++) begin
            tick(1);
            if (doneCnt != start) seen = 1;
        end
        checkOutput({tag, "_done_seen"}, 64'(seen), 64'd1);
        tick(2);
    endtask

    task automatic drainScoreboard(input string tag);
        checkOutput({tag, "_acc_count"}, 64'(obsQ.size()), 64'(expQ.size()));
        while (obsQ.size() > 0 && expQ.size() > 0)
            checkOutput({tag, "_access"}, 64'(obsQ.pop_front()), 64'(expQ.pop_front()));
        obsQ.delete();
        expQ.delete();
    endtask

    task automatic corruptGprs(input logic [31:0] base);
        for (int i = 0; i < N; i++) gpr[i] = (base + 32'(i)) ^ ($urandom | 32'd1);
    endtask

    task automatic checkGprs(input string tag, input logic [31:0] base, input int skip);
        int bad;
        bad = 0;
        for (int i = 0; i < N; i++)
            if (i != skip && gpr[i] !== base + 32'(i)) bad++;
        checkOutput({tag, "_gpr_bad"}, 64'(bad), 64'd0);
    endtask

    int b0, d0, e0, h0, r0, s0;

    task automatic snap();
        b0 = busyCnt; d0 = doneCnt; e0 = errCnt; h0 = haltRise; r0 = resumeRise; s0 = stallErr;
    endtask

    initial begin
        rst_ni = 0; save_req_i = 0; restore_req_i = 0;
        tick(3);
        checkOutput("rst_busy", 64'(busy_o), 64'd0);
        checkOutput("rst_done_err", 64'({done_o, err_o}), 64'd0);
        checkOutput("rst_valid_mismatch", 64'({ckpt_valid_o, mismatch_o}), 64'd0);
        checkOutput("rst_dbg_ctrl", 64'({debug_req_o, debug_we_o, debug_halt_o, debug_resume_o}), 64'd0);
        checkOutput("rst_dbg_data", 64'({debug_addr_o, debug_wdata_o}), 64'd0);
        rst_ni = 1;
        tick(2);

        $display("[TB] restore without checkpoint");
        snap();
        applyStimulus(0, 1);
        tick(5);
        checkOutput("nockpt_err", 64'(errCnt - e0), 64'd1);
        checkOutput("nockpt_busy", 64'(busyCnt - b0), 64'd0);
        checkOutput("nockpt_traffic", 64'(obsQ.size()), 64'd0);
        checkOutput("nockpt_halt", 64'(haltRise - h0), 64'd0);

        $display("[TB] save");
        for (int i = 0; i < N; i++) gpr[i] = 32'hA000_0000 + 32'(i);
        pushSeq(0, 32'd0);
        snap();
        applyStimulus(1, 0);
        waitDone("save");
        drainScoreboard("save");
        checkOutput("save_done_cnt", 64'(doneCnt - d0), 64'd1);
        checkOutput("save_valid", 64'(ckpt_valid_o), 64'd1);
        checkOutput("save_halt_once", 64'(haltRise - h0), 64'd1);
        checkOutput("save_resume_once", 64'(resumeRise - r0), 64'd1);
        checkOutput("save_cycles", 64'(busyCnt - b0), 64'(SAVE_CYCLES));

        $display("[TB] restore");
        corruptGprs(32'hA000_0000);
        pushRestore(32'hA000_0000);
        snap();
        applyStimulus(0, 1);
        waitDone("restore");
        drainScoreboard("restore");
        checkGprs("restore", 32'hA000_0000, -1);
        checkOutput("restore_done_cnt", 64'(doneCnt - d0), 64'd1);
        checkOutput("restore_cycles", 64'(busyCnt - b0), 64'(RESTORE_CYCLES));
        checkOutput("restore_mismatch", 64'(mismatch_o), 64'd0);
        checkOutput("restore_valid_kept", 64'(ckpt_valid_o), 64'd1);

        $display("[TB] back-pressure save");
        gntDelay = 3; rvDelay = 2;
        for (int i = 0; i < N; i++) gpr[i] = 32'hB000_0000 + 32'(i);
        pushSeq(0, 32'd0);
        snap();
        applyStimulus(1, 0);
        waitDone("bp_save");
        drainScoreboard("bp_save");
        checkOutput("bp_cycles", 64'(busyCnt - b0), 64'(BP_CYCLES));
        checkOutput("bp_stable", 64'(stallErr - s0), 64'd0);
        corruptGprs(32'hB000_0000);
        pushRestore(32'hB000_0000);
        snap();
        applyStimulus(0, 1);
        waitDone("bp_restore");
        drainScoreboard("bp_restore");
        checkOutput("bp_restore_stable", 64'(stallErr - s0), 64'd0);
        checkGprs("bp_restore", 32'hB000_0000, -1);
        gntDelay = 0; rvDelay = 0;

        $display("[TB] simultaneous and busy requests");
        corruptGprs(32'hB000_0000);
        pushRestore(32'hB000_0000);
        snap();
        applyStimulus(1, 1);
        tick(10);
        applyStimulus(1, 0);
        waitDone("simul");
        tick(20);
        drainScoreboard("simul");
        checkGprs("simul", 32'hB000_0000, -1);
        checkOutput("simul_done_cnt", 64'(doneCnt - d0), 64'd1);
        checkOutput("simul_cycles", 64'(busyCnt - b0), 64'(RESTORE_CYCLES));

`ifdef DEBUG_CKPT_VERIFY_EN
        $display("[TB] verify with dropped x5 write");
        dropX5 = 1;
        corruptGprs(32'hB000_0000);
        pushRestore(32'hB000_0000);
        snap();
        applyStimulus(0, 1);
        waitDone("verify");
        drainScoreboard("verify");
        checkGprs("verify", 32'hB000_0000, 5);
        checkOutput("verify_mismatch", 64'(mismatch_o), 64'd1);
        dropX5 = 0;
`endif

        $display("[TB] reset during save");
        applyStimulus(1, 0);
        tick(10);
        checkOutput("abort_valid_cleared", 64'(ckpt_valid_o), 64'd0);
        checkOutput("abort_busy_mid", 64'(busy_o), 64'd1);
        rst_ni = 0;
        #1;
        checkOutput("abort_busy", 64'(busy_o), 64'd0);
        checkOutput("abort_halt_resume", 64'({debug_halt_o, debug_resume_o}), 64'd0);
        checkOutput("abort_req", 64'(debug_req_o), 64'd0);
        tick(2);
        rst_ni = 1;
        obsQ.delete();
        expQ.delete();
        tick(2);

        $display("%0d/%0d checks passed", nPassed, nChecks);
        $finish;
    end

endmodule
